pe_out_requant: RTL and testbench
=================================

Name: pe_out_requant

Overview:
- Sits directly downstream of the Winograd PE core array.
- Consumes the core's per-PE 2x2 results (unpooled) or single pooled values, plus its valid strobe.
- Requantizes OUT_BIT accumulators to DATA_BIT activations: rounding right shift, optional ReLU, signed saturation.
- Packs results into fixed-width write-back words and buffers them in a small FIFO with a valid/ready output handshake toward the feature-map write-back path.

Parameters:
- X_PE, 16, number of PEs (output channels per beat)
- OUT_BIT, 24, signed width of each PE result element
- DATA_BIT, 8, signed width of each requantized activation
- SHIFT_BIT, 5, width of the shift-amount input
- FIFO_DEPTH, 8, output FIFO entries; power of two, at least 4
- AF_LEVEL, 5, FIFO occupancy at or above which almost_full is asserted

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  result beat valid, same meaning as the core's out_valid
- poolop  in  1  1 = consume result_pool, 0 = consume result_unpool; sampled with in_valid
- result_unpool  in  OUT_BIT*4*X_PE  element e of PE i at bits [(i*4+e)*OUT_BIT +: OUT_BIT]
- result_pool  in  OUT_BIT*X_PE  PE i at bits [i*OUT_BIT +: OUT_BIT]
- shift  in  SHIFT_BIT  right-shift amount; must be below OUT_BIT; sampled with in_valid
- relu_en  in  1  clamp negatives to 0; sampled with in_valid
- flush  in  1  single-cycle pulse; pushes a partial pooled word
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer accepts head
- out_data  out  DATA_BIT*4*X_PE  FIFO head word
- almost_full  out  1  FIFO occupancy >= AF_LEVEL
- overflow  out  1  sticky: a word was dropped because the FIFO was full
- mode_err  out  1  sticky: poolop changed with a partial pooled word pending

Behaviour:
- Reset (async, rst=1): all pipeline valids, pool_cnt, pack register, FIFO pointers and count cleared. out_valid=0, out_data=0, almost_full=0, overflow=0, mode_err=0.
- Stage 1 (registered, cycle t+1 after in_valid at t):
  - Each element x becomes (x + 2^(shift-1)) >>> shift, computed at OUT_BIT+1 bits to avoid overflow.
  - When shift=0, no rounding term is added.
  - Rounding is half-up; the shift is arithmetic.
- Stage 2 (registered, cycle t+2):
  - If relu_en and the value is negative, the value becomes 0.
  - The result then saturates to [-2^(DATA_BIT-1), 2^(DATA_BIT-1)-1].
- Unpooled mode:
  - Each beat forms one word directly; output element (i*4+e) occupies bits [(i*4+e)*DATA_BIT +: DATA_BIT].
  - The word is written to the FIFO at t+2.
- Pooled mode:
  - A 2-bit pool_cnt selects the slot k; beat k fills bits [k*DATA_BIT*X_PE +: DATA_BIT*X_PE], PE i at offset i*DATA_BIT within the slot.
  - When the 4th beat (k=3) is packed, the word is written to the FIFO at t+2 and pool_cnt returns to 0.
- Flush:
  - If pool_cnt != 0, the partial word is written with unfilled slots zero and pool_cnt returns to 0.
  - If pool_cnt = 0, flush has no effect.
  - If flush coincides with a stage-2 pooled beat, the beat is packed first, then the word (possibly complete) is written. Exactly one write occurs.
- Mode change:
  - A beat whose poolop differs from the pending mode while pool_cnt != 0 discards the partial word and sets mode_err.
  - The new beat is then processed normally in its own mode.
- FIFO:
  - Show-ahead; out_valid = count != 0, with out_data the head.
  - A word written at t+2 is visible on out_data/out_valid at t+3.
  - Read occurs when out_valid && out_ready.
  - A write is accepted if count < FIFO_DEPTH, or if a read occurs in the same cycle (full with simultaneous read and write: count unchanged).
  - A write when full with no read drops the word and sets overflow; FIFO contents are unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- No backpressure to the core exists. Upstream must stall issue while almost_full is high; AF_LEVEL leaves margin for the 2 in-flight pipeline stages.
- Reset mid-operation discards in-flight beats, the partial word and all FIFO contents immediately.

Test Plan:
- Unpooled, shift=4, relu_en=0, one beat with all elements 0x000018 (24) -> after 3 cycles out_valid=1, every byte 0x02 (24+8=32, >>4=2).
- Rounding/saturation: shift=1 on elements -3, 255, -300, 5 with relu_en=0 -> -1 (0xFF), 127, -128 (0x80), 3; same input with relu_en=1 -> 0, 127, 0, 3.
- Pooled, shift=0, four beats with PE values 1,2,3,4 -> exactly one word, slot k bytes = k+1; three beats then flush -> slot 3 zero; flush with pool_cnt=0 -> no write.
- Mode change: two pooled beats, then one unpooled beat -> mode_err=1, the partial word is never output, and the unpooled word is output normally.
- Backpressure: out_ready=0, 10 unpooled beats, FIFO_DEPTH=8 -> almost_full from the 5th write, overflow=1 after the 9th, only beats 1-8 drain in order once out_ready=1; full FIFO with simultaneous read and write -> no overflow.
- Assert rst asynchronously mid-burst with 3 words queued -> outputs 0 immediately, no stale word after release.

Source files
------------

// File: rtl/pe_out_requant_if.sv
// Beat/write-back bundle between the Winograd PE array, the requant stage and
// the feature-map write-back path.
interface pe_out_requant_if #(
  parameter int X_PE      = 16,
  parameter int OUT_BIT   = 24,
  parameter int DATA_BIT  = 8,
  parameter int SHIFT_BIT = 5
);
  logic                          in_valid;
  logic                          poolop;
  logic [OUT_BIT*4*X_PE-1:0]     result_unpool;
  logic [OUT_BIT*X_PE-1:0]       result_pool;
  logic [SHIFT_BIT-1:0]          shift;
  logic                          relu_en;
  logic                          flush;
  logic                          out_valid;
  logic                          out_ready;
  logic [DATA_BIT*4*X_PE-1:0]    out_data;
  logic                          almost_full;
  logic                          overflow;
  logic                          mode_err;

  modport master (
    output in_valid, poolop, result_unpool, result_pool, shift, relu_en, flush, out_ready,
    input  out_valid, out_data, almost_full, overflow, mode_err
  );
  modport slave (
    input  in_valid, poolop, result_unpool, result_pool, shift, relu_en, flush, out_ready,
    output out_valid, out_data, almost_full, overflow, mode_err
  );
endinterface

// File: rtl/pe_out_requant.sv
// Requantizes PE-array accumulators (round-shift, ReLU, saturate), packs them
// into write-back words and queues them in a show-ahead FIFO.

// One element lane: stage 1 rounding shift, stage 2 ReLU + saturation.
module pe_rq_lane #(
  parameter int OUT_BIT   = 24,
  parameter int DATA_BIT  = 8,
  parameter int SHIFT_BIT = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       s0_vld,
  input  logic                       s1_vld,
  input  logic signed [OUT_BIT-1:0]  x,
  input  logic [SHIFT_BIT-1:0]       shift,
  input  logic                       relu,
  output logic [DATA_BIT-1:0]        y
);
  localparam int W1 = OUT_BIT + 1;
  localparam logic signed [W1-1:0] CMAX = W1'((1 << (DATA_BIT-1)) - 1);
  localparam logic signed [W1-1:0] CMIN = ~CMAX;
  localparam logic [DATA_BIT-1:0] YMAX = {1'b0, {(DATA_BIT-1){1'b1}}};
  localparam logic [DATA_BIT-1:0] YMIN = {1'b1, {(DATA_BIT-1){1'b0}}};

  logic signed [W1-1:0] ext, rnd, sum, s1_q, clip;
  logic [DATA_BIT-1:0]  y_d;

  // One extra bit keeps x + 2^(shift-1) from wrapping at the positive rail.
  always_comb begin
    ext = {x[OUT_BIT-1], x};
    rnd = '0;
    if (shift != '0) rnd = W1'(1) << (shift - SHIFT_BIT'(1));
    sum = ext + rnd;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst)         s1_q <= '0;
    else if (s0_vld) s1_q <= sum >>> shift;

  always_comb begin
    clip = s1_q;
    if (relu && s1_q[W1-1]) clip = '0;
    if (clip > CMAX)      y_d = YMAX;
    else if (clip < CMIN) y_d = YMIN;
    else                  y_d = clip[DATA_BIT-1:0];
  end

  always_ff @(posedge clk or posedge rst)
    if (rst)         y <= '0;
    else if (s1_vld) y <= y_d;
endmodule

module pe_out_requant #(
  parameter int X_PE       = 16,
  parameter int OUT_BIT    = 24,
  parameter int DATA_BIT   = 8,
  parameter int SHIFT_BIT  = 5,
  parameter int FIFO_DEPTH = 8,
  parameter int AF_LEVEL   = 5
) (
  input logic            clk,
  input logic            rst,
  pe_out_requant_if.slave bus
);
  localparam int NE     = 4 * X_PE;
  localparam int W      = NE * DATA_BIT;
  localparam int STAGES = 2;
  localparam int AW     = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic pool;
    logic relu;
  } ctrl_t;

  logic [STAGES:0]                 vld_pipe;
  ctrl_t [STAGES:0]                ctrl_pipe;
  logic [NE-1:0][OUT_BIT-1:0]      lane_x;
  logic [NE-1:0][DATA_BIT-1:0]     lane_y;

  assign vld_pipe[0]  = bus.in_valid;
  assign ctrl_pipe[0] = {bus.poolop, bus.relu_en};

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      vld_pipe[STAGES:1]  <= '0;
      ctrl_pipe[STAGES:1] <= '0;
    end else begin
      vld_pipe[STAGES:1]  <= vld_pipe[STAGES-1:0];
      ctrl_pipe[STAGES:1] <= ctrl_pipe[STAGES-1:0];
    end

  // Pooled beats ride on lanes 0..X_PE-1; the upper lanes idle at zero.
  for (genvar j = 0; j < NE; j++) begin : g_lane
    if (j < X_PE) begin : g_mux
      assign lane_x[j] = bus.poolop ? bus.result_pool[j*OUT_BIT +: OUT_BIT]
                                    : bus.result_unpool[j*OUT_BIT +: OUT_BIT];
    end else begin : g_up
      assign lane_x[j] = bus.poolop ? '0 : bus.result_unpool[j*OUT_BIT +: OUT_BIT];
    end
    pe_rq_lane #(.OUT_BIT(OUT_BIT), .DATA_BIT(DATA_BIT), .SHIFT_BIT(SHIFT_BIT)) u_lane (
      .clk    (clk),
      .rst    (rst),
      .s0_vld (vld_pipe[0]),
      .s1_vld (vld_pipe[1]),
      .x      (lane_x[j]),
      .shift  (bus.shift),
      .relu   (ctrl_pipe[1].relu),
      .y      (lane_y[j])
    );
  end

  // Packing at stage 2
  logic [3:0][X_PE-1:0][DATA_BIT-1:0] pack_q, pack_d, merged;
  logic [1:0]                         pool_cnt, cnt_d;
  logic                               wr_req, merr_set;
  logic [W-1:0]                       wr_data;
  logic                               s2_pool, s2_unpool;

  assign s2_pool   = vld_pipe[STAGES] &&  ctrl_pipe[STAGES].pool;
  assign s2_unpool = vld_pipe[STAGES] && !ctrl_pipe[STAGES].pool;

  always_comb begin
    pack_d   = pack_q;
    cnt_d    = pool_cnt;
    merged   = pack_q;
    wr_req   = 1'b0;
    wr_data  = '0;
    merr_set = 1'b0;
    if (s2_unpool) begin
      wr_req  = 1'b1;
      wr_data = lane_y;
      // Only pooled words can be partial, so an unpooled beat is the only mode change.
      if (pool_cnt != 2'd0) begin
        merr_set = 1'b1;
        pack_d   = '0;
        cnt_d    = 2'd0;
      end
    end else if (s2_pool) begin
      merged[pool_cnt] = lane_y[X_PE-1:0];
      if (pool_cnt == 2'd3 || bus.flush) begin
        wr_req  = 1'b1;
        wr_data = merged;
        pack_d  = '0;
        cnt_d   = 2'd0;
      end else begin
        pack_d = merged;
        cnt_d  = pool_cnt + 2'd1;
      end
    end else if (bus.flush && pool_cnt != 2'd0) begin
      wr_req  = 1'b1;
      wr_data = pack_q;
      pack_d  = '0;
      cnt_d   = 2'd0;
    end
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pack_q   <= '0;
      pool_cnt <= 2'd0;
    end else begin
      pack_q   <= pack_d;
      pool_cnt <= cnt_d;
    end

  // Output FIFO
  logic [W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   cnt;
  logic          rd, full, wr_ok, ovf_set;
  logic          ovf_q, merr_q;

  assign full    = (cnt == (AW+1)'(FIFO_DEPTH));
  assign rd      = (cnt != '0) && bus.out_ready;
  assign wr_ok   = wr_req && (!full || rd);
  assign ovf_set = wr_req && full && !rd;

  always_ff @(posedge clk)
    if (wr_ok) mem[wptr] <= wr_data;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wptr   <= '0;
      rptr   <= '0;
      cnt    <= '0;
      ovf_q  <= 1'b0;
      merr_q <= 1'b0;
    end else begin
      if (wr_ok) wptr <= wptr + AW'(1);
      if (rd)    rptr <= rptr + AW'(1);
      case ({wr_ok, rd})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
      if (ovf_set)  ovf_q  <= 1'b1;
      if (merr_set) merr_q <= 1'b1;
    end

  assign bus.out_valid   = (cnt != '0);
  assign bus.out_data    = bus.out_valid ? mem[rptr] : '0;
  assign bus.almost_full = (cnt >= (AW+1)'(AF_LEVEL));
  assign bus.overflow    = ovf_q;
  assign bus.mode_err    = merr_q;
endmodule

// File: tb/tb_pe_out_requant.sv
// Bench for pe_out_requant: requant vector table, pooled/flush/mode/backpressure
// and reset sequences, then random beats against a plain-arithmetic model.
module tb_pe_out_requant;
  localparam int X_PE = 16, OUT_BIT = 24, DATA_BIT = 8, SHIFT_BIT = 5;
  localparam int FIFO_DEPTH = 8, AF_LEVEL = 5;
  localparam int NE = 4 * X_PE;
  localparam int W  = NE * DATA_BIT;

  typedef logic [W-1:0]              word_t;
  typedef logic [OUT_BIT*NE-1:0]     up_t;
  typedef logic [OUT_BIT*X_PE-1:0]   pl_t;

  typedef struct {
    logic signed [OUT_BIT-1:0] x;
    int                        s;
    bit                        relu;
    logic [DATA_BIT-1:0]       y;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_fail = 0;
  word_t exp_q[$];
  vec_t  tbl[18];

  always #5 clk = ~clk;

  pe_out_requant_if #(.X_PE(X_PE), .OUT_BIT(OUT_BIT), .DATA_BIT(DATA_BIT), .SHIFT_BIT(SHIFT_BIT)) bus ();

  pe_out_requant #(.X_PE(X_PE), .OUT_BIT(OUT_BIT), .DATA_BIT(DATA_BIT), .SHIFT_BIT(SHIFT_BIT),
                   .FIFO_DEPTH(FIFO_DEPTH), .AF_LEVEL(AF_LEVEL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Reference requantization: floor division of the half-up biased value.
  function automatic logic [DATA_BIT-1:0] rq(longint x, int s, bit relu);
    longint d, num, q, lim;
    d   = longint'(1) << s;
    num = x + ((s > 0) ? d / 2 : 0);
    q   = num / d;
    if ((num % d) != 0 && num < 0) q = q - 1;
    if (relu && q < 0) q = 0;
    lim = longint'(1) << (DATA_BIT - 1);
    if (q > lim - 1) q = lim - 1;
    if (q < -lim) q = -lim;
    return DATA_BIT'(q);
  endfunction

  function automatic word_t bytes_rep(logic [DATA_BIT-1:0] b);
    word_t w;
    for (int i = 0; i < NE; i++) w[i*DATA_BIT +: DATA_BIT] = b;
    return w;
  endfunction

  function automatic up_t up_rep(logic [OUT_BIT-1:0] v);
    up_t u;
    for (int i = 0; i < NE; i++) u[i*OUT_BIT +: OUT_BIT] = v;
    return u;
  endfunction

  function automatic pl_t pl_rep(logic [OUT_BIT-1:0] v);
    pl_t p;
    for (int i = 0; i < X_PE; i++) p[i*OUT_BIT +: OUT_BIT] = v;
    return p;
  endfunction

  // Slot k holds byte k+1 in every PE for the first nslots slots, zeros after.
  function automatic word_t pool_word(int nslots);
    word_t w = '0;
    for (int k = 0; k < nslots; k++)
      for (int i = 0; i < X_PE; i++) w[(k*X_PE + i)*DATA_BIT +: DATA_BIT] = DATA_BIT'(k + 1);
    return w;
  endfunction

  task automatic chk(string name, word_t act, word_t req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  task automatic idle(int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic beat(bit pool, up_t up, pl_t pl, int s, bit relu, bit fl);
    bus.in_valid      = 1'b1;
    bus.poolop        = pool;
    bus.result_unpool = up;
    bus.result_pool   = pl;
    bus.shift         = SHIFT_BIT'(s);
    bus.relu_en       = relu;
    bus.flush         = fl;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
  endtask

  task automatic pulse_flush();
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) idle(1);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: %0d words still expected, want 0", exp_q.size());
      exp_q.delete();
    end
    idle(4);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    exp_q.delete();
  endtask

  // Scoreboard: every accepted head word must match the oldest expected word.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_word: got %h want none", bus.out_data);
      end else begin
        word_t e;
        e = exp_q.pop_front();
        if (bus.out_data !== e) begin
          n_fail++;
          $display("FAIL out_word: got %h want %h", bus.out_data, e);
        end
      end
    end
  end

  initial begin
    bus.in_valid = 0; bus.poolop = 0; bus.result_unpool = '0; bus.result_pool = '0;
    bus.shift = '0; bus.relu_en = 0; bus.flush = 0; bus.out_ready = 1;

    tbl[0]  = '{24'sd24,       4,  1'b0, 8'h02};
    tbl[1]  = '{-24'sd3,       1,  1'b0, 8'hFF};
    tbl[2]  = '{24'sd255,      1,  1'b0, 8'h7F};
    tbl[3]  = '{-24'sd300,     1,  1'b0, 8'h80};
    tbl[4]  = '{24'sd5,        1,  1'b0, 8'h03};
    tbl[5]  = '{-24'sd3,       1,  1'b1, 8'h00};
    tbl[6]  = '{24'sd255,      1,  1'b1, 8'h7F};
    tbl[7]  = '{-24'sd300,     1,  1'b1, 8'h00};
    tbl[8]  = '{24'sd5,        1,  1'b1, 8'h03};
    tbl[9]  = '{24'sd100,      0,  1'b0, 8'h64};
    tbl[10] = '{-24'sd129,     0,  1'b0, 8'h80};
    tbl[11] = '{24'sd8388607,  23, 1'b0, 8'h01};
    tbl[12] = '{-24'sd8388608, 23, 1'b0, 8'hFF};
    tbl[13] = '{-24'sd2,       2,  1'b0, 8'h00};
    tbl[14] = '{-24'sd3,       2,  1'b0, 8'hFF};
    tbl[15] = '{24'sd2,        2,  1'b0, 8'h01};
    tbl[16] = '{-24'sd6,       2,  1'b0, 8'hFF};
    tbl[17] = '{-24'sd5,       2,  1'b1, 8'h00};

    idle(3);
    chk("reset_flags", word_t'({bus.out_valid, bus.almost_full, bus.overflow, bus.mode_err}), '0);
    chk("reset_data", bus.out_data, '0);
    rst = 1'b0;
    idle(1);

    // Latency: visible 3 cycles after the beat
    bus.out_ready = 0;
    beat(0, up_rep(24'd24), '0, 4, 0, 0);
    idle(1);
    chk("lat_t2_valid", word_t'(bus.out_valid), word_t'(1'b0));
    idle(1);
    chk("lat_t3_valid", word_t'(bus.out_valid), word_t'(1'b1));
    chk("lat_t3_data", bus.out_data, bytes_rep(8'h02));
    exp_q.push_back(bytes_rep(8'h02));
    drain();

    // Requant vector table, back-to-back unpooled beats
    foreach (tbl[i]) begin
      exp_q.push_back(bytes_rep(tbl[i].y));
      beat(0, up_rep(tbl[i].x), '0, tbl[i].s, tbl[i].relu, 0);
    end
    drain();

    // Pooled: four beats -> one word
    exp_q.push_back(pool_word(4));
    for (int k = 0; k < 4; k++) beat(1, '0, pl_rep(OUT_BIT'(k + 1)), 0, 0, 0);
    drain();
    // Three beats, later flush
    exp_q.push_back(pool_word(3));
    for (int k = 0; k < 3; k++) beat(1, '0, pl_rep(OUT_BIT'(k + 1)), 0, 0, 0);
    idle(3);
    pulse_flush();
    drain();
    // Three beats, flush coinciding with the third beat at stage 2
    exp_q.push_back(pool_word(3));
    for (int k = 0; k < 3; k++) beat(1, '0, pl_rep(OUT_BIT'(k + 1)), 0, 0, 0);
    idle(1);
    pulse_flush();
    drain();
    // Flush with nothing pending
    bus.out_ready = 0;
    pulse_flush();
    idle(4);
    chk("flush_empty_novalid", word_t'(bus.out_valid), word_t'(1'b0));
    bus.out_ready = 1;

    // Mode change discards the partial pooled word
    chk("mode_err_before", word_t'(bus.mode_err), word_t'(1'b0));
    beat(1, '0, pl_rep(24'd1), 0, 0, 0);
    beat(1, '0, pl_rep(24'd2), 0, 0, 0);
    exp_q.push_back(bytes_rep(8'h40));
    beat(0, up_rep(24'h40), '0, 0, 0, 0);
    drain();
    chk("mode_err_after", word_t'(bus.mode_err), word_t'(1'b1));
    exp_q.push_back(pool_word(4));
    for (int k = 0; k < 4; k++) beat(1, '0, pl_rep(OUT_BIT'(k + 1)), 0, 0, 0);
    drain();

    // Backpressure: 10 beats into an 8-deep FIFO
    bus.out_ready = 0;
    for (int n = 1; n <= 8; n++) exp_q.push_back(bytes_rep(DATA_BIT'(n)));
    for (int n = 1; n <= 4; n++) beat(0, up_rep(OUT_BIT'(n)), '0, 0, 0, 0);
    idle(3);
    chk("af_after_4", word_t'(bus.almost_full), word_t'(1'b0));
    beat(0, up_rep(24'd5), '0, 0, 0, 0);
    idle(3);
    chk("af_after_5", word_t'(bus.almost_full), word_t'(1'b1));
    for (int n = 6; n <= 8; n++) beat(0, up_rep(OUT_BIT'(n)), '0, 0, 0, 0);
    idle(3);
    chk("ovf_after_8", word_t'(bus.overflow), word_t'(1'b0));
    beat(0, up_rep(24'd9), '0, 0, 0, 0);
    idle(3);
    chk("ovf_after_9", word_t'(bus.overflow), word_t'(1'b1));
    beat(0, up_rep(24'd10), '0, 0, 0, 0);
    idle(3);
    drain();

    // Full FIFO with a simultaneous read and write keeps the word
    do_reset();
    bus.out_ready = 0;
    for (int n = 1; n <= 9; n++) exp_q.push_back(bytes_rep(DATA_BIT'(n)));
    for (int n = 1; n <= 8; n++) beat(0, up_rep(OUT_BIT'(n)), '0, 0, 0, 0);
    idle(3);
    beat(0, up_rep(24'd9), '0, 0, 0, 0);
    idle(1);
    bus.out_ready = 1;
    drain();
    chk("full_rw_no_ovf", word_t'(bus.overflow), word_t'(1'b0));

    // Asynchronous reset mid-burst
    bus.out_ready = 0;
    for (int n = 1; n <= 3; n++) beat(0, up_rep(OUT_BIT'(n + 32)), '0, 0, 0, 0);
    beat(1, '0, pl_rep(24'd7), 0, 0, 0);
    #2 rst = 1'b1;
    #1;
    chk("arst_flags", word_t'({bus.out_valid, bus.almost_full, bus.overflow, bus.mode_err}), '0);
    chk("arst_data", bus.out_data, '0);
    exp_q.delete();
    idle(2);
    rst = 1'b0;
    bus.out_ready = 1;
    idle(8);
    chk("arst_no_stale", word_t'(bus.out_valid), word_t'(1'b0));

    // Random beats against the reference model
    for (int it = 0; it < 60; it++) begin
      for (int g = 0; g < 50 && bus.almost_full; g++) begin
        bus.out_ready = 1;
        idle(1);
      end
      if (bus.almost_full) begin
        n_cmp++; n_fail++;
        $display("FAIL af_timeout: almost_full=1 want 0");
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0) begin
        word_t w = '0;
        for (int k = 0; k < 4; k++) begin
          pl_t p;
          int  s  = $urandom_range(0, OUT_BIT - 1);
          bit  rl = $urandom_range(0, 1);
          for (int i = 0; i < X_PE; i++) begin
            logic [OUT_BIT-1:0] r = OUT_BIT'($urandom);
            logic signed [OUT_BIT-1:0] xv = $signed(r) >>> $urandom_range(0, 20);
            p[i*OUT_BIT +: OUT_BIT] = xv;
            w[(k*X_PE + i)*DATA_BIT +: DATA_BIT] = rq(longint'(xv), s, rl);
          end
          if (k == 3) exp_q.push_back(w);
          beat(1, '0, p, s, rl, 0);
        end
      end else begin
        up_t   u;
        word_t w;
        int    s  = $urandom_range(0, OUT_BIT - 1);
        bit    rl = $urandom_range(0, 1);
        for (int e = 0; e < NE; e++) begin
          logic [OUT_BIT-1:0] r = OUT_BIT'($urandom);
          logic signed [OUT_BIT-1:0] xv = $signed(r) >>> $urandom_range(0, 20);
          u[e*OUT_BIT +: OUT_BIT] = xv;
          w[e*DATA_BIT +: DATA_BIT] = rq(longint'(xv), s, rl);
        end
        exp_q.push_back(w);
        beat(0, u, '0, s, rl, 0);
      end
      idle($urandom_range(0, 2));
    end
    drain();
    chk("rand_no_ovf", word_t'(bus.overflow), word_t'(1'b0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
